uart_rx_cfg: RTL and testbench

//  Parametrised UART receiver; next generation of the fixed 8N1 receiver.

---
 rtl/uart_rx_cfg_pkg.sv | 25 ++
 rtl/uart_rx_cfg_sync_edge.sv | 23 ++
 rtl/uart_rx_cfg.sv | 135 +++++++++++++
 tb/tb_uart_rx_cfg.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_cfg_pkg.sv
// Shared definitions for the configurable UART receiver: defaults, parity modes,
// FSM state encoding and the mid-bit majority helper.
package uart_rx_cfg_pkg;

  localparam int CLOCK_FRQ_DEF = 50_000_000;
  localparam int BAUD_DEF      = 115_200;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PAR     = 3'd3,
    ST_STOP    = 3'd4,
    ST_WAIT_HI = 3'd5
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_sync_edge.sv
// Three-flop synchroniser for the idle-high rx pin plus a falling-edge strobe,
// shared with the transmit-side loopback checker.
module uart_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_sync,
  output logic fall
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 3'b111;
    else        sync_q <= {sync_q[1:0], rx};
  end

  // Edge fires one cycle ahead of rx_sync going low, so the bit timer starts
  // at zero on the first low cycle of rx_sync.
  assign rx_sync = sync_q[2];
  assign fall    = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 3-sample mid-bit majority vote, optional parity,
// one or two stop bits, false-start rejection and error flags.
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int CLK_FRQ   = CLOCK_FRQ_DEF,
  parameter int BAUD      = BAUD_DEF,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_dout,
  output logic                 rx_dout_vld,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int BIT_CNT = CLK_FRQ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT);

  localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] CNT_SAMPA = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_SAMPB = CW'(HALF);
  localparam logic [CW-1:0] CNT_VOTE  = CW'(HALF + 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  rx_state_e            state, state_nxt;
  logic                 rx_s, start_edge;
  logic [CW-1:0]        cnt_bps;
  logic [3:0]           bit_idx;
  logic                 samp_a, samp_b;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad, frame_acc;
  logic                 vote_pt, bit_end, vote, last_stop, par_exp;

  uart_sync_edge u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_sync (rx_s),
    .fall    (start_edge)
  );

  assign vote_pt   = (cnt_bps == CNT_VOTE);
  assign bit_end   = (cnt_bps == CNT_LAST);
  assign vote      = maj3(samp_a, samp_b, rx_s);
  assign last_stop = (state == ST_STOP) && vote_pt && (bit_idx == STOP_LAST);
  assign busy      = (state != ST_IDLE);
  assign par_exp   = (PARITY == PAR_ODD)  ? ~(^shreg) :
                     (PARITY == PAR_EVEN) ?  (^shreg) : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // The frame closes at the last stop vote rather than at the bit end, so a
  // start edge right behind it is still caught.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start_edge) state_nxt = ST_START;
      ST_START:   if (vote_pt && vote) state_nxt = ST_IDLE;
                  else if (bit_end) state_nxt = ST_DATA;
      ST_DATA:    if (bit_end && (bit_idx == DATA_LAST))
                    state_nxt = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
      ST_PAR:     if (bit_end) state_nxt = ST_STOP;
      ST_STOP:    if (last_stop) state_nxt = vote ? ST_IDLE : ST_WAIT_HI;
      ST_WAIT_HI: if (rx_s) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_bps   <= '0;
      bit_idx   <= '0;
      samp_a    <= 1'b1;
      samp_b    <= 1'b1;
      shreg     <= '0;
      par_bad   <= 1'b0;
      frame_acc <= 1'b0;
    end else begin
      if (state == ST_IDLE || state_nxt == ST_IDLE || state_nxt == ST_WAIT_HI || bit_end)
        cnt_bps <= '0;
      else
        cnt_bps <= cnt_bps + CW'(1);

      if (cnt_bps == CNT_SAMPA) samp_a <= rx_s;
      if (cnt_bps == CNT_SAMPB) samp_b <= rx_s;

      if (state_nxt != state)
        bit_idx <= '0;
      else if (bit_end && (state == ST_DATA || state == ST_STOP))
        bit_idx <= bit_idx + 4'd1;

      if (state == ST_DATA && vote_pt)
        shreg <= {vote, shreg[DATA_BITS-1:1]};

      if (state == ST_START)
        par_bad <= 1'b0;
      else if (state == ST_PAR && vote_pt)
        par_bad <= (vote != par_exp);

      if (state == ST_START)
        frame_acc <= 1'b0;
      else if (state == ST_STOP && vote_pt && !vote)
        frame_acc <= 1'b1;
    end
  end

  // Data is delivered even on a bad frame; the flags say how far to trust it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_dout     <= '0;
      rx_dout_vld <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_dout_vld <= last_stop;
      if (last_stop) begin
        rx_dout    <= shreg;
        parity_err <= (PARITY != PAR_NONE) && par_bad;
        frame_err  <= frame_acc | ~vote;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: four differently configured instances,
// a vector table on a fast-baud instance and hand-written corner sequences.
module tb_uart_rx_cfg;

  localparam int BC   = 434;
  localparam int HALF = 217;
  localparam int BCF  = 10;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par_flip;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx_def = 1'b1, rx_par = 1'b1, rx_st2 = 1'b1, rx_fast = 1'b1;

  logic [7:0] dout_def, dout_st2, dout_fast;
  logic [6:0] dout_par;
  logic vld_def, vld_par, vld_st2, vld_fast;
  logic perr_def, perr_par, perr_st2, perr_fast;
  logic ferr_def, ferr_par, ferr_st2, ferr_fast;
  logic busy_def, busy_par, busy_st2, busy_fast;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int frame_start_cyc = 0;
  int last_vld_cyc[4];
  int vld_count[4];
  exp_t q0[$], q1[$], q2[$], q3[$];

  uart_rx_cfg u_def (
    .clk(clk), .rst_n(rst_n), .rx(rx_def), .rx_dout(dout_def), .rx_dout_vld(vld_def),
    .parity_err(perr_def), .frame_err(ferr_def), .busy(busy_def)
  );

  uart_rx_cfg #(.DATA_BITS(7), .PARITY(2)) u_par (
    .clk(clk), .rst_n(rst_n), .rx(rx_par), .rx_dout(dout_par), .rx_dout_vld(vld_par),
    .parity_err(perr_par), .frame_err(ferr_par), .busy(busy_par)
  );

  uart_rx_cfg #(.STOP_BITS(2)) u_st2 (
    .clk(clk), .rst_n(rst_n), .rx(rx_st2), .rx_dout(dout_st2), .rx_dout_vld(vld_st2),
    .parity_err(perr_st2), .frame_err(ferr_st2), .busy(busy_st2)
  );

  uart_rx_cfg #(.BAUD(5_000_000), .PARITY(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .rx(rx_fast), .rx_dout(dout_fast), .rx_dout_vld(vld_fast),
    .parity_err(perr_fast), .frame_err(ferr_fast), .busy(busy_fast)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_rx(input int inst, input logic v);
    case (inst)
      0:       rx_def  = v;
      1:       rx_par  = v;
      2:       rx_st2  = v;
      default: rx_fast = v;
    endcase
  endtask

  // Bit k of the frame is driven for bcnt cycles; one cycle may be inverted.
  task automatic drive_bits(input int inst, input logic [15:0] bits, input int nbits,
                            input int bcnt, input int pulse_bit, input int pulse_cyc);
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < bcnt; c++) begin
        @(posedge clk);
        #1;
        if (k == 0 && c == 0) frame_start_cyc = cyc;
        set_rx(inst, (k == pulse_bit && c == pulse_cyc) ? ~bits[k] : bits[k]);
      end
    end
  endtask

  task automatic idle_high(input int inst, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      set_rx(inst, 1'b1);
    end
  endtask

  task automatic applyStimulus(input int inst, input logic [8:0] data, input logic par_flip,
                               input logic [1:0] stops, input int idle,
                               input int pulse_bit, input int pulse_cyc, input exp_t e);
    int nd, par, ns, bcnt, n;
    logic [15:0] bits;
    logic x;
    case (inst)
      0:       begin nd = 8; par = 0; ns = 1; bcnt = BC;  end
      1:       begin nd = 7; par = 2; ns = 1; bcnt = BC;  end
      2:       begin nd = 8; par = 0; ns = 2; bcnt = BC;  end
      default: begin nd = 8; par = 1; ns = 1; bcnt = BCF; end
    endcase
    bits = '1;
    bits[0] = 1'b0;
    x = 1'b0;
    for (int i = 0; i < nd; i++) begin
      bits[1 + i] = data[i];
      x ^= data[i];
    end
    n = 1 + nd;
    if (par != 0) begin
      bits[n] = ((par == 1) ? ~x : x) ^ par_flip;
      n++;
    end
    for (int s = 0; s < ns; s++) bits[n + s] = stops[s];
    n += ns;
    case (inst)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      2:       q2.push_back(e);
      default: q3.push_back(e);
    endcase
    drive_bits(inst, bits, n, bcnt, pulse_bit, pulse_cyc);
    if (idle > 0) idle_high(inst, idle);
  endtask

  task automatic sb_check(input int inst, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    int sz;
    e = '{9'h0, 1'b0, 1'b0};
    case (inst)
      0:       begin sz = q0.size(); if (sz != 0) e = q0.pop_front(); end
      1:       begin sz = q1.size(); if (sz != 0) e = q1.pop_front(); end
      2:       begin sz = q2.size(); if (sz != 0) e = q2.pop_front(); end
      default: begin sz = q3.size(); if (sz != 0) e = q3.pop_front(); end
    endcase
    checkOutput($sformatf("vld_expected_i%0d", inst), int'(sz != 0), 1);
    if (sz != 0) begin
      checkOutput($sformatf("rx_dout_i%0d", inst), int'(d), int'(e.data));
      checkOutput($sformatf("parity_err_i%0d", inst), int'(pe), int'(e.perr));
      checkOutput($sformatf("frame_err_i%0d", inst), int'(fe), int'(e.ferr));
    end
    last_vld_cyc[inst] = cyc;
    vld_count[inst]++;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (vld_def)  sb_check(0, {1'b0, dout_def},  perr_def,  ferr_def);
      if (vld_par)  sb_check(1, {2'b0, dout_par},  perr_par,  ferr_par);
      if (vld_st2)  sb_check(2, {1'b0, dout_st2},  perr_st2,  ferr_st2);
      if (vld_fast) sb_check(3, {1'b0, dout_fast}, perr_fast, ferr_fast);
    end
  end

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_dout"}, int'(dout_def), 0);
    checkOutput({tag, "_vld"},  int'(vld_def),  0);
    checkOutput({tag, "_perr"}, int'(perr_def), 0);
    checkOutput({tag, "_ferr"}, int'(ferr_def), 0);
    checkOutput({tag, "_busy"}, int'(busy_def), 0);
  endtask

  initial begin
    vec_t vecs[6];
    int waited, busy_low, cnt_before;

    for (int i = 0; i < 4; i++) begin
      last_vld_cyc[i] = 0;
      vld_count[i] = 0;
    end

    // Odd parity on the fast instance: par_flip inverts the correct parity bit.
    vecs[0] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};
    vecs[3] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b1};
    vecs[4] = '{8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
    vecs[5] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0};

    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    $display("[TB] vector table on fast 8O1 instance");
    for (int i = 0; i < 6; i++)
      applyStimulus(3, {1'b0, vecs[i].data}, vecs[i].par_flip, {1'b1, vecs[i].stop}, 3 * BCF,
                    -1, 0, '{{1'b0, vecs[i].exp_data}, vecs[i].exp_perr, vecs[i].exp_ferr});

    $display("[TB] back-to-back 8N1 frames");
    applyStimulus(0, 9'h055, 1'b0, 2'b11, 0, -1, 0, '{9'h055, 1'b0, 1'b0});
    checkOutput("t1_vld_latency", last_vld_cyc[0] - frame_start_cyc, 9 * BC + HALF + 5);
    applyStimulus(0, 9'h0A3, 1'b0, 2'b11, 2 * BC, -1, 0, '{9'h0A3, 1'b0, 1'b0});

    $display("[TB] 7E1 parity good and bad");
    applyStimulus(1, 9'h041, 1'b0, 2'b11, 2 * BC, -1, 0, '{9'h041, 1'b0, 1'b0});
    applyStimulus(1, 9'h041, 1'b1, 2'b11, 2 * BC, -1, 0, '{9'h041, 1'b1, 1'b0});

    $display("[TB] false start glitch");
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1 rx_def = 1'b0;
      if (c == 5) checkOutput("t3_busy_in_glitch", int'(busy_def), 1);
    end
    rx_def = 1'b1;
    waited = 0;
    while (busy_def && waited < BC) begin
      @(posedge clk);
      #1 waited++;
    end
    checkOutput("t3_busy_cleared", int'(busy_def), 0);
    idle_high(0, BC);
    applyStimulus(0, 9'h00F, 1'b0, 2'b11, 2 * BC, -1, 0, '{9'h00F, 1'b0, 1'b0});

    $display("[TB] 8N2 second stop low then line held low");
    applyStimulus(2, 9'h03C, 1'b0, 2'b01, 0, -1, 0, '{9'h03C, 1'b0, 1'b1});
    cnt_before = vld_count[2];
    busy_low = 0;
    for (int c = 0; c < 5 * BC; c++) begin
      @(posedge clk);
      #1;
      if (!busy_st2) busy_low++;
    end
    checkOutput("t4_busy_held", busy_low, 0);
    checkOutput("t4_no_vld_while_low", vld_count[2] - cnt_before, 0);
    rx_st2 = 1'b1;
    waited = 0;
    while (busy_st2 && waited < 20) begin
      @(posedge clk);
      #1 waited++;
    end
    checkOutput("t4_busy_released", int'(busy_st2), 0);
    idle_high(2, BC);

    $display("[TB] single-cycle pulse inside data bit 3");
    applyStimulus(0, 9'h0FF, 1'b0, 2'b11, 2 * BC, 4, HALF, '{9'h0FF, 1'b0, 1'b0});

    $display("[TB] reset mid-frame");
    drive_bits(0, {6'h3F, 1'b1, 8'h96, 1'b0}, 5, BC, -1, 0);
    rst_n = 1'b0;
    rx_def = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cnt_before = vld_count[0];
    idle_high(0, 2 * BC);
    applyStimulus(0, 9'h069, 1'b0, 2'b11, 2 * BC, -1, 0, '{9'h069, 1'b0, 1'b0});
    checkOutput("t6_single_vld", vld_count[0] - cnt_before, 1);

    repeat (20) @(posedge clk);
    checkOutput("sb_drained_i0", q0.size(), 0);
    checkOutput("sb_drained_i1", q1.size(), 0);
    checkOutput("sb_drained_i2", q2.size(), 0);
    checkOutput("sb_drained_i3", q3.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
